// File: rtl/l1_icache_pkg.sv
// l1_icache_pkg: shared line/address types
// for the L1 instruction cache slice.
package l1_icache_pkg;
  localparam int LINE_WORDS = 4;
  localparam int ADDR_W = 28;
  typedef logic [ADDR_W-1:0] lineaddr_t;
  typedef logic [LINE_WORDS*32-1:0] line_t;
endpackage

// File: rtl/l1icache_core_if.sv
// l1icache_core_if: fetch-stage <-> L1 icache
// request/response handshake bundle.
interface l1icache_core_if;
  import l1_icache_pkg::*;
  logic      req_valid;
  lineaddr_t req_addr;
  logic      req_ready;
  logic      resp_valid;
  line_t     resp_data;

  modport server (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data
  );
  modport client (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/l1_icache_array.sv
// l1_icache_array: tag+data RAM, one registered
// read port, one write port, no reset.
module l1_icache_array
  import l1_icache_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 22
) (
  input  logic             clk,
  input  logic             re,
  input  logic [IDX_W-1:0] ridx,
  output logic [TAG_W-1:0] rtag,
  output line_t            rdata,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [TAG_W-1:0] wtag,
  input  line_t            wdata
);
  localparam int N = 1 << IDX_W;

  logic [TAG_W-1:0] tag_mem [N];
  line_t            data_mem [N];

  // refill writes tag and line together
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[widx]  <= wtag;
      data_mem[widx] <= wdata;
    end
  end

  // read register also captures the refill line
  always_ff @(posedge clk) begin
    if (re) begin
      rtag  <= tag_mem[ridx];
      rdata <= data_mem[ridx];
    end else if (we) begin
      rdata <= wdata;
    end
  end
endmodule

// File: rtl/l1_icache.sv
// l1_icache: direct-mapped L1 instruction cache,
// one-beat refill, one-cycle hit latency.
module l1_icache
  import l1_icache_pkg::*;
#(
  parameter int NUM_LINES = 64
) (
  input  logic  clk,
  input  logic  rst,
  l1icache_core_if.server core,
  output logic      mem_req_valid,
  output lineaddr_t mem_req_addr,
  input  logic      mem_req_ready,
  input  logic      mem_resp_valid,
  input  line_t     mem_resp_data
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  localparam logic [1:0] S_READY = 2'd0;
  localparam logic [1:0] S_MREQ  = 2'd1;
  localparam logic [1:0] S_MWAIT = 2'd2;
  localparam logic [1:0] S_RRESP = 2'd3;

  logic [1:0]           state_q;
  logic                 pend_q;
  lineaddr_t            pend_addr_q;
  logic [NUM_LINES-1:0] valid_q;
  logic                 rd_live_q;

  logic [IDX_W-1:0] pidx;
  logic [TAG_W-1:0] ptag;
  logic [TAG_W-1:0] rtag;
  line_t            rdata;
  logic             hit;
  logic             accept;
  logic             fill;

  assign pidx = pend_addr_q[IDX_W-1:0];
  assign ptag = pend_addr_q[ADDR_W-1:IDX_W];

  assign hit = pend_q && valid_q[pidx]
            && (rtag == ptag);

  assign core.req_ready = !rst
    && (state_q == S_READY)
    && !(pend_q && !hit);

  assign core.resp_valid = !rst
    && (((state_q == S_READY) && hit)
     || (state_q == S_RRESP));

  assign core.resp_data =
    (rst || !rd_live_q) ? '0 : rdata;

  assign mem_req_valid = !rst
    && (state_q == S_MREQ);
  assign mem_req_addr =
    mem_req_valid ? pend_addr_q : '0;

  assign accept = core.req_valid
               && core.req_ready;
  assign fill = !rst && mem_resp_valid
             && (state_q == S_MWAIT);

  l1_icache_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk   (clk),
    .re    (accept),
    .ridx  (core.req_addr[IDX_W-1:0]),
    .rtag  (rtag),
    .rdata (rdata),
    .we    (fill),
    .widx  (pidx),
    .wtag  (ptag),
    .wdata (mem_resp_data)
  );

  // lookup pipeline, miss FSM and valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_READY;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      valid_q     <= '0;
      rd_live_q   <= 1'b0;
    end else begin
      rd_live_q <= rd_live_q | accept | fill;
      unique case (state_q)
        S_READY: begin
          if (pend_q && !hit) begin
            state_q <= S_MREQ;
          end else begin
            pend_q <= accept;
            if (accept)
              pend_addr_q <= core.req_addr;
          end
        end
        S_MREQ: begin
          if (mem_req_ready)
            state_q <= S_MWAIT;
        end
        S_MWAIT: begin
          if (mem_resp_valid) begin
            valid_q[pidx] <= 1'b1;
            state_q       <= S_RRESP;
          end
        end
        S_RRESP: begin
          pend_q  <= 1'b0;
          state_q <= S_READY;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_l1_icache.sv
// tb_l1_icache: directed table-driven bench
// for the L1 instruction cache.
module tb_l1_icache;
  import l1_icache_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      mem_req_valid;
  lineaddr_t mem_req_addr;
  logic      mem_req_ready = 1'b1;
  logic      mem_resp_valid = 1'b0;
  line_t     mem_resp_data = '0;

  int checks = 0;
  int errors = 0;

  l1icache_core_if core_if ();

  l1_icache #(.NUM_LINES(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .core           (core_if),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    lineaddr_t addr;
    bit        miss;
    int        hold;
  } vec_t;

  vec_t vt [14];

  function automatic line_t line_of(
    input lineaddr_t a);
    return {4'hD, a, 4'hC, a,
            4'hB, a, 4'hA, a};
  endfunction

  task automatic chk(input string name,
    input logic [127:0] act,
    input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h",
               name, act, exp);
    end
  endtask

  task automatic fetch(input lineaddr_t a,
    input bit miss, input int hold);
    int rk = -1;
    int hc = 0;
    int nresp = 0;
    bit hs = 0;
    bit saw = 0;
    bit bad_rdy = 0;
    bit bad_addr = 0;
    @(negedge clk);
    chk("idle_ready", core_if.req_ready, 1);
    core_if.req_valid = 1'b1;
    core_if.req_addr  = a;
    @(negedge clk);
    core_if.req_valid = 1'b0;
    core_if.req_addr  = '0;
    for (int k = 0; k < 40; k++) begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      if (hs) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = line_of(a);
        hs = 0;
      end
      if (core_if.resp_valid) begin
        nresp++;
        if (rk < 0) rk = k;
        chk("resp_data", core_if.resp_data,
            line_of(a));
      end else if (rk < 0 && core_if.req_ready) begin
        bad_rdy = 1;
      end
      if (mem_req_valid) begin
        saw = 1;
        if (mem_req_addr !== a) bad_addr = 1;
        if (hc < hold) begin
          hc++;
          mem_req_ready  = 1'b0;
          mem_resp_valid = 1'b1;
          mem_resp_data  = ~line_of(a);
        end else begin
          mem_req_ready = 1'b1;
          hs = 1;
        end
      end else begin
        mem_req_ready = 1'b1;
      end
      if (rk >= 0 && k >= rk + 2) break;
      @(negedge clk);
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    chk("resp_count", nresp, 1);
    chk("mem_req_seen", saw, miss);
    chk("latency", rk, miss ? 3 + hold : 0);
    chk("ready_low_in_miss", bad_rdy, 0);
    chk("mem_req_addr", bad_addr, 0);
  endtask

  initial begin
    vt[0]  = '{28'h0000010, 1, 0};
    vt[1]  = '{28'h0000010, 0, 0};
    vt[2]  = '{28'h0000011, 1, 0};
    vt[3]  = '{28'h0000012, 1, 0};
    vt[4]  = '{28'h0000005, 1, 0};
    vt[5]  = '{28'h0000045, 1, 0};
    vt[6]  = '{28'h0000005, 1, 0};
    vt[7]  = '{28'h0000005, 0, 0};
    vt[8]  = '{28'h0000020, 1, 5};
    vt[9]  = '{28'h0000020, 0, 0};
    vt[10] = '{28'hFFFFFFF, 1, 0};
    vt[11] = '{28'hFFFFFFF, 0, 0};
    vt[12] = '{28'h000003F, 1, 0};
    vt[13] = '{28'hFFFFFFF, 1, 0};

    core_if.req_valid = 1'b0;
    core_if.req_addr  = '0;

    // stale refill data while in reset
    mem_resp_valid = 1'b1;
    mem_resp_data  = {4{32'h1234_5678}};
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", core_if.resp_valid, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_resp_data", core_if.resp_data, 0);
    rst = 1'b0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("post_rst_ready", core_if.req_ready, 1);
    chk("post_rst_resp_valid",
        core_if.resp_valid, 0);
    chk("post_rst_mem_req", mem_req_valid, 0);
    chk("post_rst_data", core_if.resp_data, 0);

    for (int i = 0; i < 14; i++)
      fetch(vt[i].addr, vt[i].miss, vt[i].hold);

    // back-to-back hits, one per cycle, in order
    @(negedge clk);
    core_if.req_valid = 1'b1;
    core_if.req_addr  = 28'h0000010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_valid", core_if.resp_valid, 1);
      chk("b2b_data", core_if.resp_data,
          line_of(28'h10 + 28'(i)));
      chk("b2b_ready", core_if.req_ready, 1);
      chk("b2b_no_mem", mem_req_valid, 0);
      if (i < 2)
        core_if.req_addr = 28'h11 + 28'(i);
      else
        core_if.req_valid = 1'b0;
    end
    @(negedge clk);
    chk("b2b_end", core_if.resp_valid, 0);
    chk("b2b_hold_data", core_if.resp_data,
        line_of(28'h12));

    // reset during MISS_WAIT, then late refill
    core_if.req_valid = 1'b1;
    core_if.req_addr  = 28'h0000030;
    @(negedge clk);
    core_if.req_valid = 1'b0;
    core_if.req_addr  = '0;
    @(negedge clk);
    chk("mw_mem_req", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("mw_in_wait", mem_req_valid, 0);
    chk("mw_no_resp", core_if.resp_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mw_rst_resp", core_if.resp_valid, 0);
    chk("mw_rst_mreq", mem_req_valid, 0);
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = line_of(28'h30);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("late_resp_valid", core_if.resp_valid, 0);
    chk("late_resp_data", core_if.resp_data, 0);
    chk("late_ready", core_if.req_ready, 1);
    @(negedge clk);
    chk("late_resp_valid2",
        core_if.resp_valid, 0);
    fetch(28'h0000030, 1, 0);
    fetch(28'h0000010, 1, 0);
    fetch(28'h0000010, 0, 0);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end
endmodule
